dac_stream_buffer: RTL

Elastic buffer between the UDP receive path and the DAC sample interface. Takes 32-bit payload words strobed out of the packet receiver for the DAC port, stores them in a power-of-two FIFO, and releases one I/Q sample pair per DAC sample tick once a priming threshold is reached. It absorbs Ethernet burstiness against the constant DAC rate and reports overflow and underflow as sticky status.

---
 rtl/dac_stream_buffer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dac_stream_buffer.sv
// Elastic I/Q sample FIFO between the UDP receiver and the DAC, with priming and sticky status.
// Optional DAC_BUF_LOSS_FLUSH_EN: a packet_loss rising edge flushes the FIFO and re-primes.
module dac_stream_buffer #(
  parameter int ADDR_WIDTH  = 9,
  parameter int PRIME_LEVEL = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [31:0]           data_in,
  input  logic                  data_in_valid,
  input  logic                  packet_loss,
  input  logic                  sample_tick,
  output logic [15:0]           dac_i,
  output logic [15:0]           dac_q,
  output logic                  dac_valid,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  playing,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  status_clr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PRIME_LVL = (ADDR_WIDTH+1)'(PRIME_LEVEL);

  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  rd_q;
  logic [31:0]           rdata_q;
  logic                  vld_q;
  logic [15:0]           i_q, q_q;

  logic push, pop, flush, ovf_set, unf_set;
  logic active, empty, full;
  logic loss_rise;

  logic [31:0] mem [DEPTH];

`ifdef DAC_BUF_LOSS_FLUSH_EN
  logic loss_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) loss_q <= 1'b0;
    else       loss_q <= packet_loss;
  end

  assign loss_rise = packet_loss & ~loss_q & active;
`else
  logic unused_loss;
  assign unused_loss = packet_loss;
  assign loss_rise   = 1'b0;
`endif

  assign active = (state_q != IDLE);
  assign empty  = (fill_q == '0);
  assign full   = (fill_q == FULL_LVL);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        flush = 1'b1;
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        if (fill_q >= PRIME_LVL) state_d = PLAY;
      end
      PLAY: begin
        if (sample_tick) begin
          if (empty) begin
            unf_set = 1'b1;
            state_d = PRIME;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A pop frees a slot in the same cycle, so a full FIFO can still take the word.
    if (active && data_in_valid) begin
      if (!full || pop) push = 1'b1;
      else              ovf_set = 1'b1;
    end
    if (loss_rise) begin
      flush   = 1'b1;
      push    = 1'b0;
      pop     = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      state_d = PRIME;
    end
    if (!enable) begin
      flush   = 1'b1;
      push    = 1'b0;
      pop     = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      state_d = IDLE;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fill_d = fill_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      fill_d = '0;
    end else begin
      wptr_d = wptr_q + ADDR_WIDTH'(push);
      rptr_d = rptr_q + ADDR_WIDTH'(pop);
      fill_d = fill_q + (ADDR_WIDTH+1)'(push)
                      - (ADDR_WIDTH+1)'(pop);
    end
    ovf_d = ovf_set | (ovf_q & ~status_clr);
    unf_d = unf_set | (unf_q & ~status_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fill_q  <= fill_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage and read port stay reset-free so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= data_in;
    if (pop)  rdata_q     <= mem[rptr_q];
  end

  // Output stage is not flushed, so an in-flight sample still completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= 1'b0;
      vld_q <= 1'b0;
      i_q   <= '0;
      q_q   <= '0;
    end else begin
      rd_q  <= pop;
      vld_q <= rd_q;
      if (rd_q) begin
        i_q <= rdata_q[31:16];
        q_q <= rdata_q[15:0];
      end
    end
  end

  assign dac_i      = i_q;
  assign dac_q      = q_q;
  assign dac_valid  = vld_q;
  assign fill_level = fill_q;
  assign playing    = (state_q == PLAY);
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule
